// File: rtl/analogue_decimation_ctrl.sv
// Sequencer for an analogue front-end decimation filter.
// Flushes the decimator, then clocks input samples through it and strobes
// one decimated output per cfg_ratio input samples, stopping after cfg_count
// outputs (or running until abort when cfg_count is 0).
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   cfg_ratio      input samples per output sample (0 behaves as 1)
//   cfg_count      output samples per acquisition (0 = continuous)
//   start          begin acquisition (honoured only in IDLE)
//   abort          terminate acquisition, returns to IDLE without done
//   y_ready        downstream can accept a decimated sample
//   dec_clr        decimator clear/flush
//   dec_ce         decimator input-sample clock enable
//   y_valid        decimated output sample strobe
//   busy           acquisition in progress (FLUSH or RUN)
//   done           one-cycle pulse on normal completion
//   overflow       sticky: a sample was strobed while y_ready was low
module analogue_decimation_ctrl #(
  parameter int unsigned RATIO_WIDTH  = 16,
  parameter int unsigned COUNT_WIDTH  = 12,
  parameter int unsigned FLUSH_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [RATIO_WIDTH-1:0] cfg_ratio,
  input  logic [COUNT_WIDTH-1:0] cfg_count,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   y_ready,
  output logic                   dec_clr,
  output logic                   dec_ce,
  output logic                   y_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);

  localparam int unsigned FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state;
  logic [RATIO_WIDTH-1:0] ratio_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [RATIO_WIDTH-1:0] phase;
  logic [COUNT_WIDTH-1:0] sample_cnt;
  logic [FLUSH_W-1:0]     flush_cnt;

  logic [RATIO_WIDTH-1:0] phase_nxt;
  logic [RATIO_WIDTH-1:0] ratio_last;
  logic [COUNT_WIDTH-1:0] sample_nxt;
  logic                   ratio_is_one;
  logic                   start_ok;

  // Helper terms; phase never exceeds ratio-1 so phase_nxt cannot wrap.
  assign phase_nxt    = phase + RATIO_WIDTH'(1);
  assign ratio_last   = ratio_q - RATIO_WIDTH'(1);
  assign sample_nxt   = sample_cnt + COUNT_WIDTH'(1);
  assign ratio_is_one = (ratio_q == RATIO_WIDTH'(1));
  assign start_ok     = (state == IDLE) && start && !abort;

  // State machine with registered outputs; y_valid is kept equal to (phase == ratio-1) in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ratio_q    <= '0;
      count_q    <= '0;
      phase      <= '0;
      sample_cnt <= '0;
      flush_cnt  <= '0;
      dec_clr    <= 1'b0;
      dec_ce     <= 1'b0;
      y_valid    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      // Sticky overflow, cleared only by an accepted start.
      if (start_ok) begin
        overflow <= 1'b0;
      end else if (y_valid && !y_ready) begin
        overflow <= 1'b1;
      end

      if (abort) begin
        state     <= IDLE;
        phase     <= '0;
        flush_cnt <= '0;
        dec_clr   <= 1'b0;
        dec_ce    <= 1'b0;
        y_valid   <= 1'b0;
        busy      <= 1'b0;
        done      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            done <= 1'b0;
            if (start) begin
              state      <= FLUSH;
              ratio_q    <= (cfg_ratio == '0) ? RATIO_WIDTH'(1) : cfg_ratio;
              count_q    <= cfg_count;
              sample_cnt <= '0;
              flush_cnt  <= '0;
              dec_clr    <= 1'b1;
              busy       <= 1'b1;
            end
          end

          FLUSH: begin
            if (flush_cnt == FLUSH_W'(FLUSH_CYCLES - 1)) begin
              state   <= RUN;
              dec_clr <= 1'b0;
              dec_ce  <= 1'b1;
              phase   <= '0;
              y_valid <= ratio_is_one;
            end else begin
              flush_cnt <= flush_cnt + FLUSH_W'(1);
            end
          end

          RUN: begin
            if (y_valid) begin
              sample_cnt <= sample_nxt;
              if ((count_q != '0) && (sample_nxt == count_q)) begin
                state   <= DONE;
                dec_ce  <= 1'b0;
                y_valid <= 1'b0;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else begin
                phase   <= '0;
                y_valid <= ratio_is_one;
              end
            end else begin
              phase   <= phase_nxt;
              y_valid <= (phase_nxt == ratio_last);
            end
          end

          DONE: begin
            state <= IDLE;
            done  <= 1'b0;
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/analogue_decimation_ctrl.md
ANALOGUE_DECIMATION_CTRL -- requirements
Module: analogue_decimation_ctrl

Interface
REQ-001 Parameter RATIO_WIDTH, default 16, width of decimation ratio.
REQ-002 Parameter COUNT_WIDTH, default 12, width of output-sample count.
REQ-003 Parameter FLUSH_CYCLES, default 4, cycles of decimator clear before run (>=1).
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 cfg_ratio  in  RATIO_WIDTH  input samples per output sample; 0 treated as 1.
REQ-007 cfg_count  in  COUNT_WIDTH  output samples per acquisition; 0 = continuous until abort.
REQ-008 start  in  1  begin acquisition; sampled only in IDLE.
REQ-009 abort  in  1  terminate acquisition; highest priority after rst.
REQ-010 y_ready  in  1  downstream able to accept decimated sample.
REQ-011 dec_clr  out  1  clear/flush decimator filter state.
REQ-012 dec_ce  out  1  decimator input-sample clock enable.
REQ-013 y_valid  out  1  one-cycle strobe: decimated output sample valid.
REQ-014 busy  out  1  high in FLUSH and RUN.
REQ-015 done  out  1  one-cycle pulse on normal completion.
REQ-016 overflow  out  1  sticky: y_valid issued while y_ready low.

Function
REQ-017 FSM states IDLE, FLUSH, RUN, DONE; all outputs registered.
REQ-018 IDLE: start=1 and abort=0 -> FLUSH next cycle; cfg_ratio, cfg_count latched into shadow registers on that edge; overflow cleared on that edge.
REQ-019 Config inputs changing outside the start edge have no effect on an acquisition in progress.
REQ-020 FLUSH: dec_clr=1, dec_ce=0 for exactly FLUSH_CYCLES cycles, then RUN.
REQ-021 RUN: dec_ce=1 every cycle; phase counter counts 0..ratio-1, reset to 0 on entry to RUN.
REQ-022 y_valid=1 in the RUN cycle where phase==ratio-1 (ratio 1: every RUN cycle); first y_valid in RUN cycle index ratio-1.
REQ-023 Sample counter increments on each y_valid; when it reaches latched cfg_count (non-zero), that y_valid is the last: next state DONE, dec_ce low from next cycle.
REQ-024 cfg_count=0: RUN continues indefinitely; sample counter wraps silently at 2^COUNT_WIDTH, no done.
REQ-025 y_valid with y_ready=0 sets overflow; acquisition continues, sample still counted.
REQ-026 DONE: done=1 for one cycle, busy=0, then IDLE; start during DONE ignored.
REQ-027 abort=1 in any state -> IDLE next cycle; dec_ce, dec_clr, y_valid deasserted next cycle; no done pulse; overflow retained.
REQ-028 start and abort same cycle in IDLE: remain IDLE, no config latch.
REQ-029 start while busy ignored.
REQ-030 Phase and sample counters widths RATIO_WIDTH and COUNT_WIDTH; no overflow of phase counter for any ratio up to 2^RATIO_WIDTH-1.

Reset
REQ-031 rst=1 at any edge -> IDLE; dec_clr, dec_ce, y_valid, busy, done, overflow all 0; counters and shadow registers 0.
REQ-032 rst asserted mid-acquisition takes effect on that edge; overrides start and abort.

Verification
REQ-033 ratio=4, count=3, FLUSH_CYCLES=4, y_ready=1, start pulse at cycle 0 -> dec_clr cycles 1-4, dec_ce cycles 5-16, y_valid cycles 8,12,16, done cycle 17, busy cycles 1-16, overflow 0.
REQ-034 ratio=0, count=2 -> treated as ratio 1: y_valid on first two RUN cycles, done next cycle.
REQ-035 ratio=3, count=0, run 20 RUN cycles, abort -> y_valid every third cycle, no done, all outputs low cycle after abort.
REQ-036 ratio=2, count=4, y_ready low during 2nd y_valid -> overflow set that cycle+1 and held through DONE; cleared on next start.
REQ-037 rst asserted during RUN, cfg changed during RUN -> outputs 0 next cycle; separately, cfg change mid-run does not alter y_valid spacing.
REQ-038 start+abort same cycle in IDLE; start during RUN/DONE -> no state change, busy unchanged.
